// File: rtl/multi_edge_detector.sv
// Multi-channel push-button conditioner: per channel a synchroniser, a debouncer,
// selectable edge pulse and optional hold-to-repeat pulse train.
module multi_edge_detector #(
  parameter int CH          = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int REP_CYCLES  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] w,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] rep_en,
  output logic [CH-1:0] z,
  output logic [CH-1:0] level
);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  localparam int DBW  = $clog2(DB_CYCLES) + 1;
  localparam int HMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_END = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]  REP_END  = HW'(REP_CYCLES);

  edge_mode_e edge_mode;
  logic       rep_allowed;

  assign edge_mode   = edge_mode_e'(mode);
  assign rep_allowed = (edge_mode == EDGE_RISE) || (edge_mode == EDGE_BOTH);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ws;
    logic                   s_q;
    logic                   s_d_q;
    logic [DBW-1:0]         db_cnt_q;
    logic [HW-1:0]          hold_cnt_q;
    logic                   rep_phase_q;
    logic                   z_q;
    logic                   rise;
    logic                   fall;
    logic                   hold_active;
    logic                   rep_hit;
    logic                   edge_hit;

    assign ws = sync_q[SYNC_STAGES-1];

    // NOTE: the synchroniser is reset like every other flop so that a button
    // already pressed during reset is seen as a fresh rise after release.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
      end else begin
        // NOTE: non-blocking assignments keep every stage sampling the old value.
        sync_q <= {sync_q[SYNC_STAGES-2:0], w[i]};
      end
    end

    // Debounce: the synchronised value must disagree with s for DB_CYCLES
    // consecutive cycles; any agreement in between restarts the count.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s_q      <= 1'b0;
        s_d_q    <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        s_d_q <= s_q;
        if (ws == s_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
          s_q      <= ws;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end
    end

    assign rise        = s_q & ~s_d_q;
    assign fall        = ~s_q & s_d_q;
    assign hold_active = rep_en[i] & s_q & rep_allowed;

    // First repeat after HOLD_CYCLES, then every REP_CYCLES; phase picks the period.
    assign rep_hit = hold_active &&
                     (rep_phase_q ? (hold_cnt_q == REP_END) : (hold_cnt_q == HOLD_END));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_cnt_q  <= '0;
        rep_phase_q <= 1'b0;
      end else if (!hold_active) begin
        hold_cnt_q  <= '0;
        rep_phase_q <= 1'b0;
      end else if (rep_hit) begin
        hold_cnt_q  <= HW'(1);
        rep_phase_q <= 1'b1;
      end else begin
        hold_cnt_q  <= hold_cnt_q + 1'b1;
      end
    end

    always_comb begin
      // NOTE: default first so no path through the case leaves edge_hit unassigned.
      edge_hit = 1'b0;
      case (edge_mode)
        EDGE_RISE: edge_hit = rise;
        EDGE_FALL: edge_hit = fall;
        EDGE_BOTH: edge_hit = rise | fall;
        default:   edge_hit = 1'b0;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        z_q <= 1'b0;
      end else begin
        z_q <= edge_hit | rep_hit;
      end
    end

    assign z[i]     = z_q;
    assign level[i] = s_q;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: directed scenarios plus random
// stimulus, all compared every cycle against a window/run-length reference model.
module tb_multi_edge_detector;

  localparam int CH   = 5;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] w;
  logic [1:0]    mode;
  logic [CH-1:0] rep_en;
  logic [CH-1:0] z;
  logic [CH-1:0] level;

  multi_edge_detector #(
    .CH(CH), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .w(w), .mode(mode), .rep_en(rep_en), .z(z), .level(level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: w history since reset, s decided by a DB-wide window of
  // synchronised samples, repeats from the length of the current active run.
  logic [CH-1:0] w_hist[$];
  logic [CH-1:0] s_m;
  logic [CH-1:0] s_prev;
  logic [CH-1:0] z_exp;
  int            run[CH];

  int pcnt[CH];
  int pfirst[CH];
  int plast[CH];
  int all_hits;
  int other_hits;
  int cyc = 0;

  task automatic model_reset();
    w_hist.delete();
    s_m    = '0;
    s_prev = '0;
    z_exp  = '0;
    foreach (run[c]) run[c] = 0;
  endtask

  task automatic model_step();
    logic [CH-1:0] s_next;
    int            k;
    w_hist.push_back(w);
    k      = w_hist.size() - 1;
    s_next = s_m;
    z_exp  = '0;
    for (int c = 0; c < CH; c++) begin
      bit   flip;
      bit   active;
      logic wsv;
      flip = 1'b1;
      for (int j = 0; j < DB; j++) begin
        int idx;
        idx = k - j - SYNC;
        wsv = (idx >= 0) ? w_hist[idx][c] : 1'b0;
        if (wsv == s_m[c]) flip = 1'b0;
      end
      if (flip) s_next[c] = ~s_m[c];
      active = rep_en[c] && s_m[c] && (mode == 2'b00 || mode == 2'b10);
      run[c] = active ? run[c] + 1 : 0;
      case (mode)
        2'b00:   z_exp[c] = s_m[c] & ~s_prev[c];
        2'b01:   z_exp[c] = ~s_m[c] & s_prev[c];
        2'b10:   z_exp[c] = s_m[c] ^ s_prev[c];
        default: z_exp[c] = 1'b0;
      endcase
      if (active && run[c] > HOLD && (run[c] - 1 - HOLD) % REP == 0) z_exp[c] = 1'b1;
    end
    s_prev = s_m;
    s_m    = s_next;
  endtask

  // One clock: inputs are already driven (called just after a falling edge).
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("z", z, z_exp);
    check("level", level, s_m);
    cyc++;
    for (int c = 0; c < CH; c++) begin
      if (z[c]) begin
        pcnt[c]++;
        if (pcnt[c] == 1) pfirst[c] = cyc;
        plast[c] = cyc;
      end
    end
    if (z == '1) all_hits++;
    else if (z != '0) other_hits++;
    @(negedge clk);
  endtask

  task automatic clear_counts();
    foreach (pcnt[c]) begin
      pcnt[c]   = 0;
      pfirst[c] = 0;
      plast[c]  = 0;
    end
    all_hits   = 0;
    other_hits = 0;
  endtask

  task automatic apply_reset(input int edges);
    rst = 1'b0;
    #1;
    check("rst_z", z, 0);
    check("rst_level", level, 0);
    model_reset();
    repeat (edges) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    w      = '0;
    mode   = 2'b00;
    rep_en = '0;
    rst    = 1'b0;
    clear_counts();
    apply_reset(3);
    repeat (4) tick();

    // 1: single press on channel 0, fixed latency
    w = 5'b00001;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t1_level0", level[0], (i >= 6) ? 1 : 0);
      check("t1_z0", z[0], (i == 7) ? 1 : 0);
    end

    // 2: glitch one cycle shorter than the debounce window, then a valid pulse
    clear_counts();
    w[1] = 1'b1;
    repeat (3) tick();
    w[1] = 1'b0;
    repeat (10) tick();
    check("t2_glitch_pulses", pcnt[1], 0);
    check("t2_glitch_level", level[1], 0);
    w[1] = 1'b1;
    repeat (6) tick();
    w[1] = 1'b0;
    repeat (15) tick();
    check("t2_valid_pulses", pcnt[1], 1);

    // 3: edge select on channel 2
    mode = 2'b10;
    clear_counts();
    w[2] = 1'b1;
    repeat (20) tick();
    w[2] = 1'b0;
    repeat (15) tick();
    check("t3_both_pulses", pcnt[2], 2);
    check("t3_both_spacing", plast[2] - pfirst[2], 20);
    mode = 2'b01;
    clear_counts();
    w[2] = 1'b1;
    repeat (20) tick();
    w[2] = 1'b0;
    repeat (15) tick();
    check("t3_fall_pulses", pcnt[2], 1);
    mode = 2'b11;
    clear_counts();
    w[2] = 1'b1;
    repeat (20) tick();
    w[2] = 1'b0;
    repeat (15) tick();
    check("t3_off_pulses", pcnt[2], 0);

    // 4: hold-to-repeat on channel 3: rise plus repeats at R+8,12,...,R+28
    mode   = 2'b00;
    rep_en = 5'b01000;
    clear_counts();
    w[3] = 1'b1;
    repeat (30) tick();
    w[3] = 1'b0;
    repeat (20) tick();
    check("t4_repeat_pulses", pcnt[3], 7);
    rep_en = '0;

    // 6: all channels toggled together in both-edge mode
    mode = 2'b10;
    repeat (5) tick();
    clear_counts();
    w = ~w;
    repeat (20) tick();
    check("t6_all_hits", all_hits, 1);
    check("t6_partial_hits", other_hits, 0);

    // 5: button held through reset, then asynchronous reset mid-hold
    mode   = 2'b00;
    rep_en = 5'b10000;
    w[4]   = 1'b1;
    apply_reset(4);
    clear_counts();
    repeat (12) tick();
    check("t5_rise_pulses", pcnt[4], 1);
    check("t5_level4", level[4], 1);
    repeat (10) tick();
    @(posedge clk);
    #2;
    apply_reset(2);

    // Random stimulus with varying toggle rates, mode/rep_en changes and resets
    begin
      int rate;
      rate = 8;
      for (int n = 0; n < 2000; n++) begin
        if (n % 200 == 0) rate = ((n / 200) % 3 == 0) ? 3 : (((n / 200) % 3 == 1) ? 10 : 40);
        for (int c = 0; c < CH; c++) begin
          if ($urandom_range(rate - 1) == 0) w[c] = ~w[c];
        end
        if ($urandom_range(59) == 0) mode = 2'($urandom);
        if ($urandom_range(39) == 0) rep_en = CH'($urandom);
        if ($urandom_range(599) == 0) apply_reset(2);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
